// File: rtl/shift_issue_unit.sv
// Three-position shift/rotate issue pipeline: request FIFO -> issue register -> output register.
// Optional left-direction support is enabled by defining SHIFT_LEFT_EN.
module shift_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  input  logic [4:0]                 in_amt,
  input  logic                       in_rot,
  input  logic                       in_left,
  output logic [31:0]                shf_x,
  output logic [4:0]                 shf_r,
  output logic                       shf_rot,
  input  logic [31:0]                shf_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [31:0]   r_mem_data [DEPTH];
  logic [4:0]    r_mem_amt  [DEPTH];
  logic          r_mem_rot  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          r_iss_valid;
  logic [31:0]   r_iss_x;
  logic [4:0]    r_iss_amt;
  logic          r_iss_rot;

  logic          r_out_valid;
  logic [31:0]   r_out_data;

  logic          w_push;
  logic          w_pop;
  logic          w_adv;
  logic          w_fifo_ne;
  logic [31:0]   w_head_x;
  logic [31:0]   w_result;

`ifdef SHIFT_LEFT_EN
  logic          r_mem_left [DEPTH];
  logic          r_iss_left;

  function automatic logic [31:0] f_rev(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Left operations run through the right-only barrel chain on a mirrored operand.
  assign w_head_x = r_mem_left[r_rd_ptr] ? f_rev(r_mem_data[r_rd_ptr]) : r_mem_data[r_rd_ptr];
  assign w_result = r_iss_left ? f_rev(shf_y) : shf_y;
`else
  logic          w_unused_left;
  assign w_unused_left = in_left;
  assign w_head_x = r_mem_data[r_rd_ptr];
  assign w_result = shf_y;
`endif

  assign in_ready  = (r_level < FULL_LEVEL);
  assign w_fifo_ne = (r_level != '0);
  assign w_adv     = ~r_out_valid | out_ready;
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = w_adv & w_fifo_ne & ~flush;

  assign shf_x     = r_iss_x;
  assign shf_r     = r_iss_amt;
  assign shf_rot   = r_iss_rot;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = r_level;

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_data;
      r_mem_amt[r_wr_ptr]  <= in_amt;
      r_mem_rot[r_wr_ptr]  <= in_rot;
`ifdef SHIFT_LEFT_EN
      r_mem_left[r_wr_ptr] <= in_left;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_x     <= '0;
      r_iss_amt   <= '0;
      r_iss_rot   <= 1'b0;
`ifdef SHIFT_LEFT_EN
      r_iss_left  <= 1'b0;
`endif
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_fifo_ne) begin
        r_iss_valid <= 1'b1;
        r_iss_x     <= w_head_x;
        r_iss_amt   <= r_mem_amt[r_rd_ptr];
        r_iss_rot   <= r_mem_rot[r_rd_ptr];
`ifdef SHIFT_LEFT_EN
        r_iss_left  <= r_mem_left[r_rd_ptr];
`endif
      end else begin
        r_iss_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_iss_valid;
      if (r_iss_valid) r_out_data <= w_result;
    end
  end

endmodule

// File: tb/tb_shift_issue_unit.sv
// Scoreboard bench for shift_issue_unit; the barrel-stage chain is modelled behaviourally.
module tb_shift_issue_unit;

  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef SHIFT_LEFT_EN
  localparam bit LEFT_EN = 1'b1;
`else
  localparam bit LEFT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [4:0]    in_amt;
  logic          in_rot;
  logic          in_left;
  logic [31:0]   shf_x;
  logic [4:0]    shf_r;
  logic          shf_rot;
  logic [31:0]   shf_y;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [LW-1:0] level;
  logic [63:0]   w_dbl;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  shift_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_rot(in_rot), .in_left(in_left),
    .shf_x(shf_x), .shf_r(shf_r), .shf_rot(shf_rot), .shf_y(shf_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Right-only barrel chain seen by the DUT.
  always_comb begin
    w_dbl = {shf_x, shf_x} >> shf_r;
    shf_y = shf_rot ? w_dbl[31:0] : (shf_x >> shf_r);
  end

  function automatic logic [31:0] f_model(input logic [31:0] x, input logic [4:0] a,
                                          input logic rot, input logic left);
    logic [63:0] d;
    logic [63:0] l;
    d = {x, x} >> a;
    l = {x, x} << a;
    if (left && LEFT_EN) return rot ? l[63:32] : (x << a);
    return rot ? d[31:0] : (x >> a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(f_model(in_data, in_amt, in_rot, in_left));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic r, input logic l);
    int cnt;
    in_valid = 1'b1; in_data = d; in_amt = a; in_rot = r; in_left = l;
    cnt = 0;
    while (!in_ready && cnt < 100) begin tick(); cnt++; end
    if (cnt >= 100) check("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check({tag, "_timeout"}, 32'd1, 32'd0);
    else check(tag, out_data, exp);
    tick();
  endtask

  task automatic drain();
    int cnt;
    out_ready = 1'b1;
    in_valid = 1'b0;
    cnt = 0;
    while ((exp_q.size() != 0 || out_valid || level != '0) && cnt < 200) begin tick(); cnt++; end
    if (cnt >= 200) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
    in_rot = 1'b0; in_left = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_shf_x", shf_x, 32'd0);
    check("rst_shf_r", 32'(shf_r), 32'd0);
    check("rst_shf_rot", 32'(shf_rot), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: accept at edge N, result visible after edge N+2, then cleared.
    in_valid = 1'b1; in_data = 32'h8000_0000; in_amt = 5'd16; in_rot = 1'b0; in_left = 1'b0;
    tick();
    in_valid = 1'b0;
    check("lat_n", 32'(out_valid), 32'd0);
    tick();
    check("lat_n1", 32'(out_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_data", out_data, 32'h0000_8000);
    tick();
    check("lat_clear", 32'(out_valid), 32'd0);

    send(32'h1234_5678, 5'd16, 1'b1, 1'b0);
    send(32'h1234_5678, 5'd0, 1'b1, 1'b0);
    expect_out("rot16", 32'h5678_1234);
    expect_out("amt0", 32'h1234_5678);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom();
      in_amt = 5'($urandom_range(0, 31));
      in_rot = 1'($urandom_range(0, 1));
      in_left = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Full backpressure: FIFO plus issue and output registers.
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = $urandom(); in_amt = 5'($urandom_range(0, 31));
      in_rot = 1'($urandom_range(0, 1)); in_left = 1'b0;
      if (in_ready) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'(DEPTH + 2));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_level", 32'(level), 32'(DEPTH));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("bp_stream_valid", 32'(out_valid), 32'd1);
      tick();
    end
    check("bp_stream_end", 32'(out_valid), 32'd0);
    drain();

    // Reset mid-operation with three queued and a valid result held.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send($urandom(), 5'($urandom_range(0, 31)), 1'b0, 1'b0);
    tick();
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("rst_stale", 32'(out_valid), 32'd0);
      tick();
    end

    // Flush with everything full and a push attempt in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) send($urandom(), 5'd3, 1'b1, 1'b0);
    check("fl_full_level", 32'(level), 32'(DEPTH));
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hdead_beef;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_full_level0", 32'(level), 32'd0);
    check("fl_full_valid0", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("fl_full_lost", 32'(out_valid), 32'd0);
      tick();
    end

    // Flush with room available: the same-cycle push must still be dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom(), 5'd1, 1'b0, 1'b0);
    check("fl_part_ready", 32'(in_ready), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0bad_f00d;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_part_level0", 32'(level), 32'd0);
    check("fl_part_valid0", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("fl_part_lost", 32'(out_valid), 32'd0);
      tick();
    end
    send(32'h0000_00f0, 5'd4, 1'b0, 1'b0);
    expect_out("post_flush", 32'h0000_000f);

`ifdef SHIFT_LEFT_EN
    send(32'h0000_0001, 5'd4, 1'b0, 1'b1);
    send(32'h8000_0001, 5'd1, 1'b1, 1'b1);
    expect_out("left_shift", 32'h0000_0010);
    expect_out("left_rot", 32'h0000_0003);
`else
    send(32'h0000_0010, 5'd4, 1'b0, 1'b1);
    expect_out("left_ignored", 32'h0000_0001);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
